// File: rtl/modo1_detector_jogada_pkg.sv
// rtl/modo1_detector_jogada_pkg.sv - shared state encodings, default debounce length and helpers
package modo1_detector_jogada_pkg;

    localparam int DEBOUNCE_CICLOS_PADRAO = 50000;
    localparam int CNT_W                  = 20;

    typedef enum logic [2:0] {
        OCIOSO       = 3'd0,
        FILTRA       = 3'd1,
        PULSO        = 3'd2,
        REJEITA      = 3'd3,
        ESPERA_SOLTA = 3'd4
    } estado_t;

    function automatic logic eh_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/modo1_detector_jogada_sincronizador_2ff.sv
// rtl/modo1_detector_jogada_sincronizador_2ff.sv - 4-bit two-flop synchronizer for the raw buttons
module sincronizador_2ff (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_q, meta_d;
    logic [3:0] sinc_q, sinc_d;

    always_comb begin
        meta_d = d;
        sinc_d = meta_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= 4'd0;
            sinc_q <= 4'd0;
        end else begin
            meta_q <= meta_d;
            sinc_q <= sinc_d;
        end
    end

    assign q = sinc_q;

endmodule

// File: rtl/modo1_detector_jogada.sv
// rtl/modo1_detector_jogada.sv - debounced one-hot player move detector with multi-button rejection
module modo1_detector_jogada
    import modo1_detector_jogada_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic       limpa,
    input  logic [3:0] botoes,
    output logic       jogada_feita,
    output logic [3:0] jogada,
    output logic       invalida,
    output logic [2:0] db_estado
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

    estado_t          estado_q, estado_d;
    logic [3:0]       amostra_q, amostra_d;
    logic [3:0]       jogada_q, jogada_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bs;

    sincronizador_2ff u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (botoes),
        .q     (bs)
    );

    always_comb begin
        estado_d  = estado_q;
        amostra_d = amostra_q;
        cnt_d     = cnt_q;
        jogada_d  = limpa ? 4'd0 : jogada_q;

        case (estado_q)
            OCIOSO: begin
                if (habilita && (bs != 4'd0)) begin
                    estado_d  = FILTRA;
                    amostra_d = bs;
                    cnt_d     = '0;
                end
            end
            FILTRA: begin
                if ((bs != amostra_q) || !habilita) begin
                    estado_d = OCIOSO;
                end else if (cnt_q == CNT_MAX) begin
                    // the load on PULSO entry takes priority over a coincident clear
                    if (eh_one_hot(amostra_q)) begin
                        estado_d = PULSO;
                        jogada_d = amostra_q;
                    end else begin
                        estado_d = REJEITA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PULSO, REJEITA: begin
                estado_d = ESPERA_SOLTA;
                cnt_d    = '0;
            end
            ESPERA_SOLTA: begin
                if (bs != 4'd0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    estado_d = OCIOSO;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                estado_d = OCIOSO;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            amostra_q <= 4'd0;
            cnt_q     <= '0;
            jogada_q  <= 4'd0;
        end else begin
            estado_q  <= estado_d;
            amostra_q <= amostra_d;
            cnt_q     <= cnt_d;
            jogada_q  <= jogada_d;
        end
    end

    assign jogada_feita = (estado_q == PULSO);
    assign invalida     = (estado_q == REJEITA);
    assign jogada       = jogada_q;
    assign db_estado    = estado_q;

endmodule

// File: tb/tb_modo1_detector_jogada.sv
// tb/tb_modo1_detector_jogada.sv - scoreboard bench for modo1_detector_jogada with a behavioural model
module tb_modo1_detector_jogada;

    localparam int D = 4;

    logic       clock;
    logic       reset;
    logic       habilita;
    logic       limpa;
    logic [3:0] botoes;
    logic       jogada_feita;
    logic [3:0] jogada;
    logic       invalida;
    logic [2:0] db_estado;

    modo1_detector_jogada #(.DEBOUNCE_CICLOS(D)) dut (
        .clock        (clock),
        .reset        (reset),
        .habilita     (habilita),
        .limpa        (limpa),
        .botoes       (botoes),
        .jogada_feita (jogada_feita),
        .jogada       (jogada),
        .invalida     (invalida),
        .db_estado    (db_estado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int         cyc;
        bit         press;
        logic [3:0] code;
    } ev_t;

    ev_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int pulse_count = 0;
    int inval_count = 0;
    int last_pulse_cyc = -1;
    int last_inval_cyc = -1;

    logic [3:0] exp_jogada = 4'd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    task automatic fail_now(input string name, input int a, input int b);
        total++;
        bad++;
        $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, a, b, cyc);
    endtask

    // Reference: a press is a nonzero value seen by the bench for D+1 edges with
    // habilita high, after which D clean zero edges are needed to re-arm.
    initial begin : model
        logic [3:0] b1, b2, bs, cand;
        bit filtering, releasing, pending, evento;
        int held, quiet;
        ev_t e;
        b1 = 0; b2 = 0; cand = 0;
        filtering = 0; releasing = 0; pending = 0;
        held = 0; quiet = 0;
        forever begin
            @(posedge clock);
            cyc++;
            if (reset) begin
                b1 = 0; b2 = 0;
                filtering = 0; releasing = 0; pending = 0;
                held = 0; quiet = 0;
                exp_jogada = 4'd0;
            end else begin
                bs = b2;
                b2 = b1;
                b1 = botoes;
                evento = 0;
                if (pending) begin
                    pending   = 0;
                    releasing = 1;
                    quiet     = 0;
                end else if (releasing) begin
                    if (bs != 0) quiet = 0;
                    else begin
                        quiet++;
                        if (quiet == D) releasing = 0;
                    end
                end else if (filtering) begin
                    if (bs != cand || !habilita) filtering = 0;
                    else begin
                        held++;
                        if (held == D) begin
                            filtering = 0;
                            pending   = 1;
                            e.cyc     = cyc;
                            e.press   = ($countones(cand) == 1);
                            e.code    = cand;
                            exp_q.push_back(e);
                            if (e.press) begin
                                exp_jogada = cand;
                                evento     = 1;
                            end
                        end
                    end
                end else if (habilita && bs != 0) begin
                    filtering = 1;
                    cand      = bs;
                    held      = 0;
                end
                if (!evento && limpa) exp_jogada = 4'd0;
            end
        end
    end

    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
            end else begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    fail_now("missed_event", cyc, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
                if (jogada_feita && invalida) fail_now("both_pulses", 1, 0);
                if (jogada_feita) begin pulse_count++; last_pulse_cyc = cyc; end
                if (invalida)     begin inval_count++; last_inval_cyc = cyc; end
                if (jogada_feita || invalida) begin
                    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                        e = exp_q.pop_front();
                        chk("event_kind_press", {31'd0, jogada_feita}, {31'd0, e.press});
                        if (e.press) chk("event_code", {28'd0, jogada}, {28'd0, e.code});
                    end else begin
                        fail_now("unexpected_event", cyc, -1);
                    end
                end
                chk("jogada_track", {28'd0, jogada}, {28'd0, exp_jogada});
            end
        end
    end

    task automatic tick(input logic [3:0] b, input logic h, input logic l);
        @(posedge clock);
        #2;
        botoes   = b;
        habilita = h;
        limpa    = l;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(4'd0, 1'b1, 1'b0);
    endtask

    int t0, p0, i0;
    logic [3:0] v;
    bit h;
    int len;

    initial begin : stim
        reset = 1'b1; habilita = 1'b0; limpa = 1'b0; botoes = 4'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_jogada_feita", {31'd0, jogada_feita}, 0);
        chk("rst_invalida", {31'd0, invalida}, 0);
        chk("rst_jogada", {28'd0, jogada}, 0);
        chk("rst_db_estado", {29'd0, db_estado}, 0);
        #1;
        reset = 1'b0;
        idle(5);

        // single clean press held for 20 cycles
        p0 = pulse_count;
        tick(4'b0010, 1'b1, 1'b0);
        t0 = cyc + 1;
        repeat (19) tick(4'b0010, 1'b1, 1'b0);
        chk("press_count", pulse_count - p0, 1);
        chk("press_latency", last_pulse_cyc, t0 + D + 2);
        chk("press_code", {28'd0, jogada}, 4'b0010);
        chk("held_espera_solta", {29'd0, db_estado}, 4);
        idle(10);
        chk("released_ocioso", {29'd0, db_estado}, 0);

        // bouncing input never settles long enough
        p0 = pulse_count;
        repeat (3) begin
            repeat (2) tick(4'b0001, 1'b1, 1'b0);
            repeat (2) tick(4'b0000, 1'b1, 1'b0);
        end
        idle(10);
        chk("bounce_no_pulse", pulse_count - p0, 0);
        chk("bounce_ocioso", {29'd0, db_estado}, 0);
        chk("bounce_jogada_kept", {28'd0, jogada}, 4'b0010);

        // two buttons at once are rejected
        p0 = pulse_count; i0 = inval_count;
        tick(4'b0101, 1'b1, 1'b0);
        t0 = cyc + 1;
        repeat (9) tick(4'b0101, 1'b1, 1'b0);
        idle(10);
        chk("multi_inval_count", inval_count - i0, 1);
        chk("multi_inval_latency", last_inval_cyc, t0 + D + 2);
        chk("multi_no_pulse", pulse_count - p0, 0);
        chk("multi_jogada_kept", {28'd0, jogada}, 4'b0010);

        // button held while disabled, then enabled
        p0 = pulse_count;
        repeat (10) tick(4'b1000, 1'b0, 1'b0);
        chk("disabled_no_pulse", pulse_count - p0, 0);
        tick(4'b1000, 1'b1, 1'b0);
        t0 = cyc + 1;
        repeat (9) tick(4'b1000, 1'b1, 1'b0);
        chk("enable_pulse_count", pulse_count - p0, 1);
        chk("enable_latency", last_pulse_cyc, t0 + D);
        chk("enable_code", {28'd0, jogada}, 4'b1000);
        idle(10);

        // reset in the middle of filtering
        p0 = pulse_count;
        repeat (6) tick(4'b0100, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_feita", {31'd0, jogada_feita}, 0);
        chk("midrst_jogada", {28'd0, jogada}, 0);
        chk("midrst_estado", {29'd0, db_estado}, 0);
        chk("midrst_no_pulse", pulse_count - p0, 0);
        repeat (2) tick(4'b0100, 1'b1, 1'b0);
        tick(4'b0100, 1'b1, 1'b0);
        reset = 1'b0;
        t0 = cyc + 1;
        repeat (10) tick(4'b0100, 1'b1, 1'b0);
        chk("postrst_pulse_count", pulse_count - p0, 1);
        chk("postrst_latency", last_pulse_cyc, t0 + D + 2);
        idle(10);

        // clear coincident with the load, then clear one cycle later
        p0 = pulse_count;
        tick(4'b0001, 1'b1, 1'b0);
        t0 = cyc + 1;
        repeat (5) tick(4'b0001, 1'b1, 1'b0);
        tick(4'b0001, 1'b1, 1'b1);
        tick(4'b0001, 1'b1, 1'b1);
        chk("limpa_load_wins", {28'd0, jogada}, 4'b0001);
        chk("limpa_entry_pulse", {31'd0, jogada_feita}, 1);
        tick(4'b0001, 1'b1, 1'b0);
        chk("limpa_clears", {28'd0, jogada}, 0);
        chk("limpa_pulse_once", pulse_count - p0, 1);
        idle(10);

        // randomized traffic
        repeat (250) begin
            case ($urandom_range(0, 9))
                0, 1, 2:    v = 4'd0;
                3, 4, 5, 6: v = 4'd1 << $urandom_range(0, 3);
                default:    v = 4'($urandom_range(0, 15));
            endcase
            h   = ($urandom_range(0, 7) != 0);
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++)
                tick(v, h, ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b1;
                repeat (2) tick(v, h, 1'b0);
                reset = 1'b0;
            end
        end

        idle(20);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modo1_detector_jogada.md
MODO1_DETECTOR_JOGADA -- requirements
Module: modo1_detector_jogada

Interface
REQ-001 Parameter DEBOUNCE_CICLOS, default 50000, SHALL set the stable-sample count required for press and for release (1 ms at 50 MHz); legal range is 2..2^20.
REQ-002 clock  input  1  SHALL be the system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 habilita  input  1  SHALL enable press acceptance; it is driven by the control unit's vez_jogador.
REQ-005 limpa  input  1  SHALL be a synchronous clear of the jogada register; it is driven by zeraR.
REQ-006 botoes  input  4  SHALL carry the raw, asynchronous, active-high player buttons.
REQ-007 jogada_feita  output  1  SHALL be a one-cycle pulse marking each accepted press.
REQ-008 jogada  output  4  SHALL hold the one-hot code of the last accepted press.
REQ-009 invalida  output  1  SHALL be a one-cycle pulse marking a rejected multi-button press.
REQ-010 db_estado  output  3  SHALL expose the current state encoding.

Function
REQ-011 botoes SHALL pass through a 2-flop synchronizer; all logic below uses only the synchronized value bs.
REQ-012 The FSM SHALL have these states and encodings: OCIOSO=0, FILTRA=1, PULSO=2, REJEITA=3, ESPERA_SOLTA=4; encodings 5-7 SHALL go to OCIOSO.
REQ-013 OCIOSO: if habilita=1 and bs!=0, the FSM SHALL go to FILTRA, capture amostra<=bs, and set cnt<=0; otherwise it stays in OCIOSO.
REQ-014 FILTRA: if bs!=amostra or habilita=0, the FSM SHALL go to OCIOSO.
REQ-015 FILTRA: otherwise, if cnt==DEBOUNCE_CICLOS-1, the FSM SHALL go to PULSO when amostra is one-hot and to REJEITA when it is not.
REQ-016 FILTRA: otherwise the FSM SHALL increment cnt and stay.
REQ-017 PULSO: jogada_feita=1 for exactly this cycle; jogada SHALL be loaded with amostra on the edge entering PULSO; the next state SHALL be ESPERA_SOLTA with cnt<=0.
REQ-018 REJEITA: invalida=1 for this cycle; jogada SHALL be unchanged; the next state SHALL be ESPERA_SOLTA with cnt<=0.
REQ-019 ESPERA_SOLTA: if bs!=0, cnt SHALL be set to 0; if bs==0 and cnt==DEBOUNCE_CICLOS-1, the FSM SHALL go to OCIOSO; otherwise cnt SHALL increment; habilita SHALL be ignored in this state.
REQ-020 Press latency: jogada_feita SHALL assert exactly DEBOUNCE_CICLOS+3 rising edges after the first edge that samples a stable new botoes value (2 synchronizer + 1 capture + DEBOUNCE_CICLOS filter).
REQ-021 A button held continuously SHALL produce exactly one jogada_feita; a new pulse requires a debounced release first.
REQ-022 A button already held when habilita rises SHALL be accepted as a press, except when it is being held through ESPERA_SOLTA.
REQ-023 limpa=1 SHALL set jogada to 0 on the next edge and SHALL NOT alter the FSM or cnt.
REQ-024 If limpa=1 on the edge entering PULSO, the load SHALL win and jogada SHALL become amostra.
REQ-025 cnt SHALL be 20 bits wide and SHALL never exceed DEBOUNCE_CICLOS-1; it SHALL NOT wrap.
REQ-026 jogada_feita and invalida SHALL be Moore outputs decoded from the state; they SHALL never both be 1.

Reset
REQ-027 While reset=1: state=OCIOSO, synchronizer flops=0, amostra=0, cnt=0, jogada=0, jogada_feita=0, invalida=0, db_estado=0.
REQ-028 Reset asserted mid-filter or mid-pulse SHALL abort the operation with no jogada_feita emitted; after release, a press requires a full new filter window.

Structure
REQ-029 State encodings and the default DEBOUNCE_CICLOS SHALL live in a shared include file used by the control unit and the top level.
REQ-030 The synchronizer SHALL be one sub-module, sincronizador_2ff, 4 bits wide, with asynchronous reset.
REQ-031 Implementation size is about 150-250 lines of RTL; no other sub-modules.

Verification (bench SHALL use DEBOUNCE_CICLOS=4)
REQ-032 habilita=1, botoes=4'b0010 held for 20 cycles -> one jogada_feita pulse exactly 7 edges after the first sample, jogada=4'b0010, db_estado=4 until release plus 4 clean cycles.
REQ-033 botoes toggles 4'b0001/0 every 2 cycles for 12 cycles, then stays 0 -> no jogada_feita, FSM ends in OCIOSO, jogada unchanged.
REQ-034 botoes=4'b0101 stable for 10 cycles -> invalida pulses once 7 edges after the sample, no jogada_feita, jogada unchanged.
REQ-035 habilita=0 with botoes=4'b1000 -> no pulse; habilita raised while the button is still held -> one pulse 5 edges later (1 capture + 4 filter).
REQ-036 reset asserted 3 cycles into FILTRA -> all outputs 0 immediately; after release, the held button yields a pulse DEBOUNCE_CICLOS+3 edges after reset deasserts.
REQ-037 limpa=1 coincident with the PULSO entry edge -> jogada=new code; limpa=1 one cycle later -> jogada=0 while jogada_feita is unaffected.
